// File: rtl/cmp_pkg.sv
// Shared definitions for the CMP per-node data memory: data width, FSM encoding
// and the helper that sizes the ignored upper part of the CPU word address.
package cmp_pkg;

    localparam int DW     = 64;
    localparam int CPU_AW = 32;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } dmem_state_e;

    // Number of CPU address bits above the AW-bit word index that never select a word.
    function automatic int addr_ignored_bits(input int aw);
        return CPU_AW - aw;
    endfunction

endpackage

// File: rtl/cmp_dmem_array.sv
// Single-port synchronous RAM with a registered read; the contents are never reset.
module cmp_dmem_array #(
    parameter int AW = 8,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem [0:DEPTH-1];
    logic [DW-1:0] rdata_q;

    // A write leaves the read register untouched so the last read result stays visible.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata_q <= mem[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/cmp_dmem.sv
// Per-node CMP data memory: one-cycle CPU port, post-reset zero-fill engine and a
// lower-priority valid/ready debug port, all sharing one array port.
module cmp_dmem #(
    parameter int AW = 8,
    parameter int DW = cmp_pkg::DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   cpu_addr,
    input  logic          cpu_en,
    input  logic          cpu_wren,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dbg_valid,
    output logic          dbg_ready,
    input  logic          dbg_wr,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    output logic          clear_done
);

    import cmp_pkg::*;

    localparam int IGN_W = addr_ignored_bits(AW);

    logic [AW-1:0] cpu_word;
    logic          unused_addr_bits;

    assign cpu_word         = cpu_addr[AW-1:0];
    assign unused_addr_bits = ^cpu_addr[CPU_AW-1 -: IGN_W];

    dmem_state_e   state_q, state_d;
    logic [AW-1:0] clear_cnt_q, clear_cnt_d;
    logic          clear_done_q, clear_done_d;
    logic          cpu_rd_q, cpu_rd_d;
    logic          dbg_rd_q, dbg_rd_d;
    logic [DW-1:0] cpu_hold_q, cpu_hold_d;
    logic [DW-1:0] dbg_hold_q, dbg_hold_d;

    logic          arr_en;
    logic          arr_we;
    logic [AW-1:0] arr_addr;
    logic [DW-1:0] arr_wdata;
    logic [DW-1:0] arr_rdata;

    cmp_dmem_array #(
        .AW (AW),
        .DW (DW)
    ) u_array (
        .clk   (clk),
        .en    (arr_en),
        .we    (arr_we),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    assign dbg_ready = (state_q == RUN) && !cpu_en;

    // Arbitration: the CPU always wins, the clear engine stalls behind it, debug gets leftovers.
    always_comb begin
        state_d      = state_q;
        clear_cnt_d  = clear_cnt_q;
        clear_done_d = clear_done_q;
        cpu_rd_d     = 1'b0;
        dbg_rd_d     = 1'b0;
        arr_en       = 1'b0;
        arr_we       = 1'b0;
        arr_addr     = '0;
        arr_wdata    = '0;

        if (cpu_en) begin
            arr_en    = 1'b1;
            arr_we    = cpu_wren;
            arr_addr  = cpu_word;
            arr_wdata = cpu_wdata;
            cpu_rd_d  = !cpu_wren;
        end else if (state_q == CLEAR) begin
            arr_en      = 1'b1;
            arr_we      = 1'b1;
            arr_addr    = clear_cnt_q;
            clear_cnt_d = clear_cnt_q + 1'b1;
            if (&clear_cnt_q) begin
                state_d      = RUN;
                clear_done_d = 1'b1;
            end
        end else if (dbg_valid) begin
            arr_en    = 1'b1;
            arr_we    = dbg_wr;
            arr_addr  = dbg_addr;
            arr_wdata = dbg_wdata;
            dbg_rd_d  = !dbg_wr;
        end
    end

    // The array read register is shared, so each port captures it only after its own read.
    always_comb begin
        cpu_hold_d = cpu_rd_q ? arr_rdata : cpu_hold_q;
        dbg_hold_d = dbg_rd_q ? arr_rdata : dbg_hold_q;
    end

    assign cpu_rdata  = cpu_hold_d;
    assign dbg_rdata  = dbg_hold_d;
    assign dbg_rvalid = dbg_rd_q;
    assign clear_done = clear_done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= CLEAR;
            clear_cnt_q  <= '0;
            clear_done_q <= 1'b0;
            cpu_rd_q     <= 1'b0;
            dbg_rd_q     <= 1'b0;
            cpu_hold_q   <= '0;
            dbg_hold_q   <= '0;
        end else begin
            state_q      <= state_d;
            clear_cnt_q  <= clear_cnt_d;
            clear_done_q <= clear_done_d;
            cpu_rd_q     <= cpu_rd_d;
            dbg_rd_q     <= dbg_rd_d;
            cpu_hold_q   <= cpu_hold_d;
            dbg_hold_q   <= dbg_hold_d;
        end
    end

endmodule

// File: tb/tb_cmp_dmem.sv
// Directed bench for cmp_dmem with AW=4: clear timing, CPU/debug ports, priority,
// aliasing, clear stalled by a CPU write, and reset during a debug read.
module tb_cmp_dmem;

    localparam int AW = 4;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   cpu_addr;
    logic          cpu_en;
    logic          cpu_wren;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          dbg_valid;
    logic          dbg_ready;
    logic          dbg_wr;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_rvalid;
    logic [DW-1:0] dbg_rdata;
    logic          clear_done;

    int checks = 0;
    int errors = 0;

    cmp_dmem #(
        .AW (AW),
        .DW (DW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_en     (cpu_en),
        .cpu_wren   (cpu_wren),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .dbg_valid  (dbg_valid),
        .dbg_ready  (dbg_ready),
        .dbg_wr     (dbg_wr),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .clear_done (clear_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic dbg_write(input logic [AW-1:0] a, input logic [63:0] d);
        dbg_valid = 1'b1;
        dbg_wr    = 1'b1;
        dbg_addr  = a;
        dbg_wdata = d;
        #1;
        chk("dbg_wr_ready", dbg_ready, 1'b1);
        @(posedge clk);
        #1;
        dbg_valid = 1'b0;
    endtask

    task automatic dbg_read(input logic [AW-1:0] a, input logic [63:0] exp);
        dbg_valid = 1'b1;
        dbg_wr    = 1'b0;
        dbg_addr  = a;
        tick();
        dbg_valid = 1'b0;
        chk("dbg_rd_rvalid", dbg_rvalid, 1'b1);
        chk("dbg_rd_data", dbg_rdata, exp);
    endtask

    task automatic cpu_access(input logic wr, input logic [31:0] a, input logic [63:0] d);
        cpu_en    = 1'b1;
        cpu_wren  = wr;
        cpu_addr  = a;
        cpu_wdata = d;
        tick();
        cpu_en    = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        cpu_addr  = '0;
        cpu_en    = 1'b0;
        cpu_wren  = 1'b0;
        cpu_wdata = '0;
        dbg_valid = 1'b0;
        dbg_wr    = 1'b0;
        dbg_addr  = '0;
        dbg_wdata = '0;

        // Reset state
        #12;
        chk("rst_cpu_rdata", cpu_rdata, 64'h0);
        chk("rst_dbg_rdata", dbg_rdata, 64'h0);
        chk("rst_dbg_rvalid", dbg_rvalid, 1'b0);
        chk("rst_clear_done", clear_done, 1'b0);
        chk("rst_dbg_ready", dbg_ready, 1'b0);

        // Clear takes exactly 16 cycles after release
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk("clr_done_low", clear_done, 1'b0);
            chk("clr_ready_low", dbg_ready, 1'b0);
        end
        tick();
        chk("clr_done_16", clear_done, 1'b1);
        chk("clr_ready_16", dbg_ready, 1'b1);

        for (int i = 0; i < 16; i++) begin
            dbg_read(AW'(i), 64'h0);
        end
        tick();
        chk("rvalid_pulse", dbg_rvalid, 1'b0);

        // Debug write, CPU read, hold
        dbg_write(4'd5, 64'hDEADBEEF_00000001);
        cpu_access(1'b0, 32'd5, 64'h0);
        chk("cpu_rd5", cpu_rdata, 64'hDEADBEEF_00000001);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("cpu_rd5_hold", cpu_rdata, 64'hDEADBEEF_00000001);
        end

        // CPU write then read through an aliased address
        cpu_access(1'b1, 32'd3, 64'h1111);
        chk("cpu_wr_keeps_rdata", cpu_rdata, 64'hDEADBEEF_00000001);
        cpu_access(1'b0, 32'h0000_0103, 64'h0);
        chk("cpu_rd_alias3", cpu_rdata, 64'h1111);
        cpu_access(1'b1, 32'h0000_0017, 64'h77);
        dbg_read(4'd7, 64'h77);

        // CPU and debug contend for two cycles
        dbg_write(4'd9, 64'h9999);
        dbg_valid = 1'b1;
        dbg_wr    = 1'b0;
        dbg_addr  = 4'd9;
        cpu_en    = 1'b1;
        cpu_wren  = 1'b0;
        cpu_addr  = 32'd5;
        #1;
        chk("cont_ready0_a", dbg_ready, 1'b0);
        tick();
        chk("cont_rvalid0_a", dbg_rvalid, 1'b0);
        cpu_addr = 32'd3;
        #1;
        chk("cont_ready0_b", dbg_ready, 1'b0);
        tick();
        chk("cont_rvalid0_b", dbg_rvalid, 1'b0);
        chk("cont_cpu_rd3", cpu_rdata, 64'h1111);
        cpu_en = 1'b0;
        #1;
        chk("cont_ready1", dbg_ready, 1'b1);
        tick();
        dbg_valid = 1'b0;
        chk("cont_rvalid1", dbg_rvalid, 1'b1);
        chk("cont_rdata", dbg_rdata, 64'h9999);
        tick();
        chk("cont_rvalid_end", dbg_rvalid, 1'b0);
        chk("cont_rdata_hold", dbg_rdata, 64'h9999);

        // Back-to-back debug write then read of the same word
        dbg_write(4'd10, 64'hA0A0);
        dbg_valid = 1'b1;
        dbg_wr    = 1'b0;
        tick();
        dbg_valid = 1'b0;
        chk("b2b_rvalid", dbg_rvalid, 1'b1);
        chk("b2b_rdata", dbg_rdata, 64'hA0A0);

        // Reset for one cycle while a debug read is being accepted
        dbg_valid = 1'b1;
        dbg_wr    = 1'b0;
        dbg_addr  = 4'd5;
        #1;
        chk("mid_ready", dbg_ready, 1'b1);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_cpu_rdata", cpu_rdata, 64'h0);
        chk("mid_dbg_rdata", dbg_rdata, 64'h0);
        chk("mid_clear_done", clear_done, 1'b0);
        chk("mid_dbg_ready", dbg_ready, 1'b0);
        @(posedge clk);
        #1;
        chk("mid_rvalid", dbg_rvalid, 1'b0);
        reset     = 1'b1;
        dbg_valid = 1'b0;

        // CPU write during clear cycle 10 delays clear_done to cycle 17
        for (int i = 1; i <= 9; i++) begin
            tick();
        end
        cpu_access(1'b1, 32'd0, 64'hC0FFEE);
        for (int i = 11; i <= 16; i++) begin
            tick();
        end
        chk("stall_done_16", clear_done, 1'b0);
        tick();
        chk("stall_done_17", clear_done, 1'b1);
        chk("stall_rvalid", dbg_rvalid, 1'b0);
        cpu_access(1'b0, 32'd0, 64'h0);
        chk("stall_word0", cpu_rdata, 64'hC0FFEE);
        dbg_read(4'd5, 64'h0);
        dbg_read(4'd0, 64'hC0FFEE);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmp_dmem.md
Name: cmp_dmem

Overview:
- Per-node data memory that sits directly downstream of one CMP node's data-memory port (dmemAddr/dmemEn/dmemWrEn/dmemDataout in, dmemDataIn out).
- Four instances are placed next to the CMP, one per node.
- Provides a fixed one-cycle-latency read/write port to the CPU, plus a lower-priority debug port with a valid/ready handshake. The testbench uses the debug port to preload and dump memory.
- Contains a post-reset clear engine that zero-fills the array.

Parameters:
AW, 8, word-address width; depth = 2**AW words
DW, 64, data word width; fixed at 64 for the CMP

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset
cpu_addr  input  32  [0:31] word address; bits [32-AW:31] used, upper bits ignored
cpu_en  input  1  access request this cycle
cpu_wren  input  1  1 = write, 0 = read (qualified by cpu_en)
cpu_wdata  input  DW  [0:63] write data
cpu_rdata  output  DW  [0:63] read data, valid the cycle after the read
dbg_valid  input  1  debug request valid
dbg_ready  output  1  debug request accepted when dbg_valid & dbg_ready
dbg_wr  input  1  1 = write, 0 = read
dbg_addr  input  AW  word address
dbg_wdata  input  DW  write data
dbg_rvalid  output  1  one-cycle pulse, debug read data valid
dbg_rdata  output  DW  debug read data
clear_done  output  1  high once the post-reset clear has completed

Behaviour:
- Reset (reset low, asynchronous):
  - cpu_rdata=0, dbg_rdata=0, dbg_rvalid=0, clear_done=0.
  - FSM enters CLEAR, clear counter=0.
  - The array itself is not reset.
  - A debug read in flight is dropped; no rvalid is issued.
- FSM states:
  - CLEAR: writes 0 to word clear_cnt, then increments the counter. After word 2**AW-1 is written, the FSM moves to RUN on the next edge and clear_done rises.
  - RUN: normal operation; stays in RUN until reset.
- Port priority each cycle: CPU > clear engine > debug. There is a single array port, so exactly one access occurs per cycle.
- CPU write (cpu_en & cpu_wren): mem[addr] <= cpu_wdata at the edge. cpu_rdata holds its previous value.
- CPU read (cpu_en & !cpu_wren): cpu_rdata <= mem[addr] at the edge, so data is visible one cycle after the request. cpu_rdata holds until the next CPU read.
- The CPU is always served, including during CLEAR. That cycle's clear write is skipped and clear_cnt holds, so a CPU write during CLEAR is never overwritten by a later clear of a different word.
  - Exception: a CPU write to a word not yet cleared is overwritten when the clear reaches it. Software must wait for clear_done.
- dbg_ready = (state==RUN) & !cpu_en. This is combinational, with no dependence on dbg_valid.
- Debug write accepted: mem[dbg_addr] <= dbg_wdata.
- Debug read accepted: dbg_rdata <= mem[dbg_addr] and dbg_rvalid=1 on the next cycle only. dbg_rdata holds until the next debug read.
- Back-to-back debug accepts are allowed every cycle. A read issued the cycle after a write to the same address returns the new data.
- Address wrap: only the low AW bits of cpu_addr select the word, so aliasing is silent.
- No read-during-write forwarding is needed, because there is a single port.
- Worst-case clear duration with no CPU traffic: 2**AW cycles after reset release.

Decomposition:
- Shared package cmp_pkg holds:
  - DW=64;
  - FSM state encoding (CLEAR=1'b0, RUN=1'b1);
  - the address-slice helper constant (32-AW).
- One natural sub-module: cmp_dmem_array, a single-port synchronous RAM (addr, en, we, wdata, rdata, registered read).
  - Arbitration, the FSM and output holding registers stay in cmp_dmem.

Test Plan:
- Reset release, no traffic, AW=4: clear_done rises exactly 16 cycles after reset goes high, and dbg_ready is 0 until then. Debug reads of words 0..15 afterwards all return 0.
- After clear, debug write 0xDEADBEEF_00000001 to addr 5, then CPU read cpu_addr=5 → cpu_rdata=0xDEADBEEF_00000001 one cycle later. The value holds while cpu_en=0 for 3 cycles.
- CPU write 0x1111 to addr 3 in cycle N, CPU read addr 3 in cycle N+1 → cpu_rdata=0x1111 in N+2. Address 0x00000103 with AW=8 aliases to word 3.
- CPU and debug contend: dbg_valid=1 with cpu_en=1 for 2 cycles → dbg_ready=0 both cycles and no debug access occurs. The debug access is accepted on the first cycle with cpu_en=0, and dbg_rvalid pulses exactly one cycle later.
- CPU write to addr 0 at clear cycle 10 (AW=4) → clear_cnt holds for that cycle, clear_done is delayed by 1 cycle to cycle 17, and word 0 reads back the CPU value.
- Assert reset for 1 cycle mid-RUN, with a debug read accepted in the same cycle → dbg_rvalid stays 0, clear_done drops to 0, and all outputs read 0.
